// File: rtl/mips32_mem_pkg.sv
// Shared encodings and defaults for the MIPS32 unified-memory arbiter.
package mips32_mem_pkg;

   localparam int unsigned DEF_AW = 32;
   localparam int unsigned DEF_DW = 32;
   localparam int unsigned WCNT_W = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCESS = 2'd1;
   localparam state_t ST_RESP   = 2'd2;

   typedef logic [1:0] owner_t;
   localparam owner_t OWN_NONE = 2'd0;
   localparam owner_t OWN_IF   = 2'd1;
   localparam owner_t OWN_D    = 2'd2;

endpackage

// File: rtl/mips32_arb_pick.sv
// Winner selection between IF fetch and MEM data requests; data normally wins.
// ARB_STARVE_GUARD_EN adds a saturating counter that lets fetch win after STARVE_LIMIT losses.
module mips32_arb_pick
   import mips32_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_ok,
   input  logic if_req,
   input  logic d_req,
   output logic pick_if,
   output logic pick_d
);

`ifdef ARB_STARVE_GUARD_EN
   localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] starve_q;
   logic [SW-1:0] starve_d;
   logic          force_if;

   assign force_if = (starve_q >= SW'(STARVE_LIMIT));

   always_comb begin
      pick_if = grant_ok & if_req & (~d_req | force_if);
      pick_d  = grant_ok & d_req & ~pick_if;
   end

   always_comb begin
      starve_d = starve_q;
      if (!if_req || pick_if) begin
         starve_d = '0;
      end else if (pick_d && (starve_q < SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_pick;
   assign unused_pick = &{1'b0, clk, rst, (STARVE_LIMIT == 0)};

   always_comb begin
      pick_d  = grant_ok & d_req;
      pick_if = grant_ok & if_req & ~d_req;
   end
`endif

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter for IF fetch and MEM LW/SW: IDLE/ACCESS/RESP FSM with registered mem_* controls.
// Optional fetch starvation guard: ARB_STARVE_GUARD_EN (implemented in mips32_arb_pick).
module mips32_mem_arbiter
   import mips32_mem_pkg::*;
#(
   parameter int unsigned AW           = DEF_AW,
   parameter int unsigned DW           = DEF_DW,
   parameter int unsigned WAIT_STATES  = 0,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   state_t              state_q, state_d;
   owner_t              owner_q, owner_d;
   logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
   logic                acc_we_q, acc_we_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [AW-1:0]       mem_addr_q, mem_addr_d;
   logic [DW-1:0]       mem_wdata_q, mem_wdata_d;

   logic grant_ok;
   logic pick_if;
   logic pick_d;
   logic resp;

   // Grants are suppressed while rst is high so the reset cycle never starts an access.
   assign grant_ok = ~rst & ((state_q == ST_IDLE) | (state_q == ST_RESP));

   mips32_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk      (clk),
      .rst      (rst),
      .grant_ok (grant_ok),
      .if_req   (if_req),
      .d_req    (d_req),
      .pick_if  (pick_if),
      .pick_d   (pick_d)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wcnt_d      = wcnt_q;
      acc_we_d    = acc_we_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         ST_ACCESS: begin
            if (wcnt_q == '0) begin
               state_d  = ST_RESP;
               mem_en_d = 1'b0;
               mem_we_d = 1'b0;
            end else begin
               wcnt_d = wcnt_q - WCNT_W'(1);
            end
         end
         default: begin
            if (pick_d) begin
               state_d     = ST_ACCESS;
               owner_d     = OWN_D;
               wcnt_d      = WCNT_W'(WAIT_STATES);
               acc_we_d    = d_we;
               mem_en_d    = 1'b1;
               mem_we_d    = d_we;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
            end else if (pick_if) begin
               state_d     = ST_ACCESS;
               owner_d     = OWN_IF;
               wcnt_d      = WCNT_W'(WAIT_STATES);
               acc_we_d    = 1'b0;
               mem_en_d    = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
            end else begin
               state_d  = ST_IDLE;
               owner_d  = OWN_NONE;
               acc_we_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_NONE;
         wcnt_q      <= '0;
         acc_we_q    <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wcnt_q      <= wcnt_d;
         acc_we_q    <= acc_we_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   always_comb begin
      resp      = (state_q == ST_RESP);
      if_gnt    = pick_if;
      d_gnt     = pick_d;
      if_rvalid = resp & (owner_q == OWN_IF);
      d_rvalid  = resp & (owner_q == OWN_D);
      if_rdata  = if_rvalid ? mem_rdata : '0;
      d_rdata   = (d_rvalid & ~acc_we_q) ? mem_rdata : '0;
      busy      = (state_q == ST_ACCESS) | resp;
      mem_en    = mem_en_q;
      mem_we    = mem_we_q;
      mem_addr  = mem_addr_q;
      mem_wdata = mem_wdata_q;
   end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: instance A (WAIT_STATES=0) and instance B (WAIT_STATES=2).
module tb_mips32_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] init_a(input int i);
      if (i == 5)   return 32'h1443_1000;
      if (i == 200) return 32'd7;
      return 32'h1000_0000 + i;
   endfunction

   function automatic logic [31:0] init_b(input int i);
      return 32'hB000_0000 + i;
   endfunction

   // ---------------- instance A ----------------
   logic        rst_a = 1'b1;
   logic        if_req_a = 1'b0, d_req_a = 1'b0, d_we_a = 1'b0;
   logic [31:0] if_addr_a = '0, d_addr_a = '0, d_wdata_a = '0;
   logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a;
   logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a;
   logic        mem_en_a, mem_we_a, busy_a;
   logic [31:0] mem_rdata_a;
   logic [31:0] mem_a [256];
   logic [31:0] ref_a [256];

   mips32_mem_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(4)) dut_a (
      .clk(clk), .rst(rst_a),
      .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
      .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
      .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
      .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
   );

   always @(posedge clk) begin
      if (rst_a) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= init_a(i);
         mem_rdata_a <= '0;
      end else if (mem_en_a) begin
         if (mem_we_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
         mem_rdata_a <= mem_a[mem_addr_a[7:0]];
      end
   end

   typedef struct {
      logic        src_d;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t sb[$];
   logic glog[$];
   logic log_en = 1'b0;
   int   last_if_gnt_cyc = -1;
   int   last_d_rv_cyc   = -1;

   // Monitor: pop/compare responses first, then push expectations for this cycle's grant.
   always @(negedge clk) begin
      if (rst_a) begin
         for (int i = 0; i < 256; i++) ref_a[i] = init_a(i);
         sb.delete();
      end else begin
         if (if_rvalid_a || d_rvalid_a) begin
            if (d_rvalid_a) last_d_rv_cyc = cyc;
            if (sb.size() == 0) begin
               chk("spurious_rvalid", {30'd0, if_rvalid_a, d_rvalid_a}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_src_d", {31'd0, d_rvalid_a}, {31'd0, e.src_d});
               chk("rsp_src_if", {31'd0, if_rvalid_a}, {31'd0, ~e.src_d});
               chk("rsp_data", e.src_d ? d_rdata_a : if_rdata_a, e.data);
               chk("rsp_nonowner", e.src_d ? if_rdata_a : d_rdata_a, 32'd0);
               chk("rsp_latency", cyc, e.due);
            end
         end
         if (if_gnt_a && d_gnt_a) chk("one_gnt", {30'd0, if_gnt_a, d_gnt_a}, 32'd2);
         if (d_gnt_a) begin
            exp_t e;
            e.src_d = 1'b1;
            e.data  = d_we_a ? 32'd0 : ref_a[d_addr_a[7:0]];
            e.due   = cyc + 2;
            sb.push_back(e);
            if (d_we_a) ref_a[d_addr_a[7:0]] = d_wdata_a;
            if (log_en) glog.push_back(1'b0);
         end else if (if_gnt_a) begin
            exp_t e;
            e.src_d = 1'b0;
            e.data  = ref_a[if_addr_a[7:0]];
            e.due   = cyc + 2;
            sb.push_back(e);
            last_if_gnt_cyc = cyc;
            if (log_en) glog.push_back(1'b1);
         end
      end
   end

   // Drivers: call and return just after a posedge; request held until granted.
   task automatic a_if(input logic [31:0] addr);
      if_req_a  = 1'b1;
      if_addr_a = addr;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if_gnt_a) break;
      end
      chk("if_gnt_wait", {31'd0, if_gnt_a}, 32'd1);
      @(posedge clk); #1;
      if_req_a = 1'b0;
   endtask

   task automatic a_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      d_req_a   = 1'b1;
      d_we_a    = we;
      d_addr_a  = addr;
      d_wdata_a = wdata;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (d_gnt_a) break;
      end
      chk("d_gnt_wait", {31'd0, d_gnt_a}, 32'd1);
      @(posedge clk); #1;
      d_req_a = 1'b0;
      d_we_a  = 1'b0;
   endtask

   // ---------------- instance B ----------------
   logic        rst_b = 1'b1;
   logic        if_req_b = 1'b0, d_req_b = 1'b0, d_we_b = 1'b0;
   logic [31:0] if_addr_b = '0, d_addr_b = '0, d_wdata_b = '0;
   logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b;
   logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b;
   logic        mem_en_b, mem_we_b, busy_b;
   logic [31:0] mem_rdata_b;
   logic [31:0] mem_b [256];

   mips32_mem_arbiter #(.WAIT_STATES(2), .STARVE_LIMIT(4)) dut_b (
      .clk(clk), .rst(rst_b),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
      .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
      .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
      .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   always @(posedge clk) begin
      if (rst_b) begin
         for (int i = 0; i < 256; i++) mem_b[i] <= init_b(i);
         mem_rdata_b <= '0;
      end else if (mem_en_b) begin
         if (mem_we_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
         mem_rdata_b <= mem_b[mem_addr_b[7:0]];
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int we_cnt;
      int ifg;
      int dg;
      int lat;
      logic [31:0] rd;
      logic [5:0] exp_seq;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy_a}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en_a}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid_a, d_rvalid_a}, 32'd0);
      chk("rst_mem_addr", mem_addr_a, 32'd0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(posedge clk); #1;

      // Fetch from word 5 with no wait states.
      a_if(32'd5);
      @(negedge clk);
      chk("f_mem_en", {31'd0, mem_en_a}, 32'd1);
      chk("f_mem_addr", mem_addr_a, 32'd5);
      chk("f_mem_we", {31'd0, mem_we_a}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("f_busy_low", {31'd0, busy_a}, 32'd0);
      @(posedge clk); #1;

      // Simultaneous fetch and load: data first, fetch granted in the load's RESP cycle.
      fork
         a_d(1'b0, 32'd200, 32'd0);
         a_if(32'd3);
      join
      chk("sim_if_gnt_in_resp", last_if_gnt_cyc, last_d_rv_cyc);
      repeat (4) @(posedge clk); #1;

      // Store then load back.
      a_d(1'b1, 32'd198, 32'd5040);
      we_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mem_we_a) we_cnt++;
      end
      chk("st_we_cycles", we_cnt, 1);
      @(posedge clk); #1;
      a_d(1'b0, 32'd198, 32'd0);
      repeat (4) @(posedge clk); #1;
      chk("st_mem199", mem_a[199], 32'h1000_00C7);
      chk("st_mem198", mem_a[198], 32'd5040);

      // Both requesters held continuously.
      d_req_a  = 1'b1; d_we_a = 1'b0; d_addr_a = 32'd10;
      if_req_a = 1'b1; if_addr_a = 32'd11;
      log_en   = 1'b1;
      repeat (24) @(posedge clk);
      #1;
      d_req_a  = 1'b0;
      if_req_a = 1'b0;
      log_en   = 1'b0;
      repeat (4) @(posedge clk); #1;
      ifg = 0; dg = 0;
      foreach (glog[i]) if (glog[i]) ifg++; else dg++;
      chk("starve_d_gnts_seen", {31'd0, dg >= 8}, 32'd1);
`ifdef ARB_STARVE_GUARD_EN
      exp_seq = 6'b010000;
      chk("starve_len", {31'd0, glog.size() >= 6}, 32'd1);
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("starve_seq", {31'd0, glog[i]}, {31'd0, exp_seq[i]});
`else
      exp_seq = '0;
      chk("starve_if_gnts", ifg, {26'd0, exp_seq});
`endif
      chk("sb_empty", sb.size(), 0);

      // Instance B: single load with two wait states.
      d_req_b = 1'b1; d_we_b = 1'b0; d_addr_b = 32'd40;
      @(negedge clk);
      chk("b_d_gnt", {31'd0, d_gnt_b}, 32'd1);
      @(posedge clk); #1;
      d_req_b = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk("b_mem_en", {31'd0, mem_en_b}, {31'd0, k <= 3});
         chk("b_d_rvalid", {31'd0, d_rvalid_b}, {31'd0, k == 4});
         chk("b_if_rvalid", {31'd0, if_rvalid_b}, 32'd0);
         if (k == 4) chk("b_d_rdata", d_rdata_b, init_b(40));
      end
      @(posedge clk); #1;

      // Instance B: reset during ACCESS of a store.
      d_req_b = 1'b1; d_we_b = 1'b1; d_addr_b = 32'd60; d_wdata_b = 32'h5A5A;
      @(negedge clk);
      chk("br_d_gnt", {31'd0, d_gnt_b}, 32'd1);
      @(posedge clk); #1;
      d_req_b = 1'b0; d_we_b = 1'b0;
      @(negedge clk);
      chk("br_mem_we_access", {31'd0, mem_we_b}, 32'd1);
      rst_b = 1'b1;
      @(negedge clk);
      chk("br_mem_en", {31'd0, mem_en_b}, 32'd0);
      chk("br_mem_we", {31'd0, mem_we_b}, 32'd0);
      chk("br_busy", {31'd0, busy_b}, 32'd0);
      chk("br_d_rvalid", {31'd0, d_rvalid_b}, 32'd0);
      rst_b = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("br_no_rvalid", {31'd0, d_rvalid_b}, 32'd0);
      end
      @(posedge clk); #1;

      // Instance B: fresh fetch after reset.
      if_req_b = 1'b1; if_addr_b = 32'd7;
      @(negedge clk);
      chk("bf_if_gnt", {31'd0, if_gnt_b}, 32'd1);
      @(posedge clk); #1;
      if_req_b = 1'b0;
      lat = 0; rd = '0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (if_rvalid_b) begin
            lat = k;
            rd  = if_rdata_b;
            break;
         end
      end
      chk("bf_latency", lat, 4);
      chk("bf_rdata", rd, init_b(7));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/mips32_mem_arbiter.md
Name: mips32_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters of the MIPS32 pipeline: the IF-stage instruction fetch and the MEM-stage LW/SW data access.
- Holds a request/grant handshake with each requester and registers the memory control signals.
- Inserts configurable wait states and returns read data or a write acknowledge to the access owner.
- Allows the processor to run against a realistic memory macro instead of a dual-ported array.

Parameters:
- AW, 32, word-address width (word-indexed, matching the Mem[] word array).
- DW, 32, data width.
- WAIT_STATES, 0, extra cycles mem_en is held beyond the first (0..15).
- STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win (only used with the optional feature).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  AW  fetch word address.
- if_gnt  out  1  fetch grant pulse (combinational, one cycle).
- if_rvalid  out  1  fetch data valid pulse.
- if_rdata  out  DW  fetch data.
- d_req  in  1  data request; held with other d_* inputs stable until d_gnt.
- d_we  in  1  1 = SW, 0 = LW.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data grant pulse.
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  DW  load data.
- mem_en  out  1  memory enable (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  AW  memory address (registered).
- mem_wdata  out  DW  memory write data (registered).
- mem_rdata  in  DW  memory read data; valid the cycle after the last mem_en cycle.
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset values: all outputs 0, state IDLE, wait counter 0, owner none, starve counter 0.
- States and transitions:
  - IDLE: grant allowed.
  - ACCESS: mem_en=1 for WAIT_STATES+1 cycles. Counter loads WAIT_STATES on entry and decrements each cycle. Exit to RESP when the counter is 0.
  - RESP: owner's rvalid=1. For reads, rdata = mem_rdata. For writes, rvalid is the ack and rdata = 0. Grant allowed. Next state is ACCESS if a grant occurs this cycle, else IDLE.
- Grant cycle T, only in IDLE or RESP with a request present:
  - Exactly one gnt is asserted.
  - Winner's addr, we and wdata are latched into the mem_* registers.
  - Owner is latched.
- Timing: ACCESS occupies T+1 .. T+1+WAIT_STATES; rvalid at T+2+WAIT_STATES. Load-to-use latency is 2+WAIT_STATES cycles; throughput is one access per WAIT_STATES+2 cycles.
- mem_we is high only during ACCESS of a write. mem_en, mem_we, mem_addr and mem_wdata are held constant throughout ACCESS.
- Arbitration: data beats fetch (the MEM stage is older than IF, which avoids deadlock). A simultaneous if_req and d_req grants d; if_req stays pending.
- rvalid and rdata of the non-owner are always 0.
- A request withdrawn before gnt is ignored. Requests are never queued internally.
- rst mid-operation: the next cycle is IDLE with all outputs 0. The in-flight access is dropped, no rvalid is issued, and a partially-held write is abandoned.
- Address and data pass through unmodified; no alignment checks.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro:
  - A saturating counter increments on each grant to d while if_req is high.
  - It clears on an if_gnt, and also clears whenever if_req is low.
  - When the counter reaches STARVE_LIMIT, fetch wins the next arbitration even if d_req is high.
- Without the macro: strict data priority; no counter logic is synthesised.

Decomposition:
- Package mips32_mem_pkg:
  - state encoding (IDLE, ACCESS, RESP);
  - owner encoding (OWN_NONE, OWN_IF, OWN_D);
  - default AW and DW;
  - wait-counter width constant (4).
- Sub-module mips32_arb_pick: combinational winner selection plus the optional starvation counter, registered on clk/rst. The top level holds the FSM and the mem_* registers.

Test Plan:
- Fetch, WAIT_STATES=0, memory preloaded with Mem[5]=32'h14431000: if_req with if_addr=5 at T -> if_gnt at T; mem_en=1 and mem_addr=5 at T+1; if_rvalid=1 with if_rdata=32'h14431000 at T+2; busy low at T+3.
- Simultaneous if_req (addr 3) and d_req (LW, addr 200, Mem[200]=7) -> d_gnt first; d_rvalid with d_rdata=7; if_gnt in that same RESP cycle; fetch data returned 2 cycles later.
- Store: d_we=1, d_addr=198, d_wdata=5040 -> mem_we=1 for exactly 1 cycle; d_rvalid ack; a following LW from 198 returns 5040; Mem[199] is unchanged.
- WAIT_STATES=2: single LW -> mem_en high for 3 consecutive cycles; d_rvalid at T+4; no other rvalid.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4, d_req and if_req held high continuously -> grant sequence d,d,d,d,if,d,...
- Same starvation stimulus without ARB_STARVE_GUARD_EN -> if_gnt never asserted.
- rst asserted during ACCESS of a write -> next cycle mem_en=0, mem_we=0, busy=0; no d_rvalid.
- After rst release, a fresh if_req is served normally.
